snake_mover: RTL and testbench
==============================

# snake_mover

Generates and advances one snake's packed body vector and length, one segment per move tick. It drives the `snake`/`len` inputs of the collision checker and consumes that checker's stop flag. It sits between the input/direction logic and the collision checker, one instance per player.

## Interface
- `max_len`, 16: body capacity in segments.
- `num_len`, 10: bits per segment.
  - Segment layout is `{y[num_len/2-1:0], x[num_len/2-1:0]}`, with x in the low half.
- `max_len_bit_len`, 4: width of `len`.
- `START_X`, 8: head x after reset or restart.
- `START_Y`, 8: head y after reset or restart.
- `INIT_LEN`, 3: length after reset or restart. Must satisfy 1 ≤ `INIT_LEN` ≤ `START_X`+1.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  enters RUN from IDLE; restarts from DEAD.
- `tick`  in  1  move strobe, one cycle per step.
- `dir`  in  2  requested direction: 0 up (y−1), 1 down (y+1), 2 left (x−1), 3 right (x+1).
- `dir_valid`  in  1  qualifies `dir`.
- `grow`  in  1  request one extra segment.
- `stop`  in  1  collision stop flag from the checker.
- `snake`  out  `max_len*num_len`  packed body. Segment i is `snake[i*num_len +: num_len]`; segment 0 is the head.
- `len`  out  `max_len_bit_len`  current segment count.
- `alive`  out  1  high in RUN.
- `moved`  out  1  one-cycle pulse when a step commits.

## Operation
- States:
  - IDLE (reset state).
  - RUN.
  - DEAD.
- Reset layout, used by `rst`, and also loaded by `start` in DEAD:
  - Segment i = (`START_X`−i, `START_Y`) for i < `INIT_LEN`.
  - All other segments are 0.
  - `len`=`INIT_LEN`.
  - Current direction = right.
  - Grow pending = 0.
- Reset values of outputs: `snake` = reset layout, `len`=`INIT_LEN`, `alive`=0, `moved`=0.
- IDLE:
  - `start` → RUN.
  - `tick`, `grow` and `dir_valid` are ignored.
- RUN, direction handling:
  - `dir_valid` latches `dir` into pending direction unless it is the exact reverse of the current direction; a reverse request is dropped.
  - Pending direction becomes current only at a step.
  - The reverse check is made against the current direction, not the pending one.
- RUN, grow handling:
  - `grow` sets the one-bit grow-pending flag.
  - Multiple `grow` pulses before a step still yield one segment.
- RUN, step on `tick` with `stop`=0:
  - New head = head moved one cell in the current (updated) direction. Each coordinate wraps modulo 2^(`num_len`/2).
  - Body shifts up one segment; segment i+1 takes old segment i.
  - If grow is pending and `len` < `max_len`−1: `len`+1, and the old tail is retained.
  - Otherwise `len` is unchanged.
  - Segments at index ≥ new `len` are forced to 0.
  - Grow-pending is cleared at every step, including when `len` is saturated.
- RUN, `stop`=1 (with or without `tick`):
  - → DEAD.
  - No step.
  - `snake` and `len` freeze.
- DEAD:
  - `snake` and `len` hold.
  - `start` reloads the reset layout → RUN.
  - All other inputs are ignored.

## Timing
- Inputs are sampled on the rising edge of `clk`.
- Step latency:
  - Updated `snake`/`len` are visible the cycle after `tick` is sampled.
  - `moved` is high for exactly that cycle.
- A `dir_valid` and `tick` in the same cycle: the new direction applies to that step, subject to the reverse check.
- A `grow` and `tick` in the same cycle: the grow applies to that step.
- `stop` has priority over `tick`.
- `alive` falls the cycle after `stop` is sampled.
- `rst` mid-operation: immediately returns all outputs to their reset values, regardless of clock.
- `tick` held high: one step per cycle.

## Configuration
- `SNAKE_WALL_KILL_EN` defined:
  - A step whose new head coordinate would wrap (x or y crossing 0 ↔ max) does not commit.
  - The block goes to DEAD, `snake`/`len` freeze, and `moved` stays 0.
- `SNAKE_WALL_KILL_EN` undefined: coordinates wrap silently (default).

## Test plan
- Reset, `start`, `tick` → segments 0..2 become 265, 264, 263 (from 264, 263, 262); `len`=3; `moved` pulses 1 cycle; `alive`=1.
- Moving right, `dir_valid` with `dir`=2 (left), then `tick` → head x increments (reverse dropped). Then `dir`=0, `tick` → head y decrements.
- Head at x=31 moving right, `tick` → x=0, same y. With `SNAKE_WALL_KILL_EN`: DEAD, `snake` unchanged.
- `grow` twice, then `tick` → `len` 3→4, segment 3 = old segment 2. Next `tick` → `len` stays 4. Growing to 15 then `grow`+`tick` → `len` stays 15.
- `stop` and `tick` in the same cycle → no step, `alive`=0 next cycle, `snake` frozen. `start` → reset layout, RUN.
- Assert `rst` mid-step with `tick`=1 → outputs equal reset values, IDLE, and `tick` is ignored until `start`.

Source files
------------

// File: rtl/snake_mover_if.sv
// Bundles the player-side control strobes and the body outputs of one snake_mover.
// The master side drives the strobes and the slave side (the mover) returns the body.
interface snake_mover_if #(
  parameter int MAX_LEN = 16,
  parameter int NUM_LEN = 10,
  parameter int LEN_W   = 4
);
  // start, tick, dir_valid and grow are single-cycle strobes sampled on the
  // rising clock edge; there is no backpressure, every strobe is consumed.
  logic                       start;
  logic                       tick;
  logic [1:0]                 dir;
  logic                       dir_valid;
  logic                       grow;
  logic                       stop;
  logic [MAX_LEN*NUM_LEN-1:0] snake;
  logic [LEN_W-1:0]           len;
  logic                       alive;
  logic                       moved;
  logic [1:0]                 state_dbg;

  modport master (
    output start, tick, dir, dir_valid, grow, stop,
    input  snake, len, alive, moved, state_dbg
  );

  modport slave (
    input  start, tick, dir, dir_valid, grow, stop,
    output snake, len, alive, moved, state_dbg
  );
endinterface

// File: rtl/snake_mover.sv
// Advances one snake's packed body (head at segment 0) one cell per move tick.
// Define SNAKE_WALL_KILL_EN to kill the snake on a wrapping step instead of wrapping.
module snake_mover #(
  parameter int max_len         = 16,
  parameter int num_len         = 10,
  parameter int max_len_bit_len = 4,
  parameter int START_X         = 8,
  parameter int START_Y         = 8,
  parameter int INIT_LEN        = 3
) (
  input logic           clk,
  input logic           rst,
  snake_mover_if.slave  bus
);

  localparam int HALF    = num_len / 2;
  localparam int SNAKE_W = max_len * num_len;

  localparam logic [1:0] D_UP    = 2'd0;
  localparam logic [1:0] D_DOWN  = 2'd1;
  localparam logic [1:0] D_LEFT  = 2'd2;
  localparam logic [1:0] D_RIGHT = 2'd3;

  localparam logic [max_len_bit_len-1:0] GROW_LIMIT = max_len_bit_len'(max_len - 1);
  localparam logic [max_len_bit_len-1:0] LEN_INIT   = max_len_bit_len'(INIT_LEN);

`ifdef SNAKE_WALL_KILL_EN
  localparam bit WALL_KILL = 1'b1;
`else
  localparam bit WALL_KILL = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DEAD = 2'd2
  } state_t;

  function automatic logic [SNAKE_W-1:0] reset_layout();
    logic [SNAKE_W-1:0] v;
    v = '0;
    for (int i = 0; i < max_len; i++) begin
      if (i < INIT_LEN) begin
        v[i*num_len +: num_len] = {HALF'(START_Y), HALF'(START_X - i)};
      end
    end
    return v;
  endfunction

  state_t                     state_q, state_d;
  logic [SNAKE_W-1:0]         snake_q, snake_d;
  logic [max_len_bit_len-1:0] len_q, len_d;
  logic [1:0]                 cur_dir_q, cur_dir_d;
  logic [1:0]                 pend_dir_q, pend_dir_d;
  logic                       grow_q, grow_d;
  logic                       moved_q, moved_d;

  logic [HALF-1:0]            head_x, head_y, nx, ny;
  logic [1:0]                 eff_dir;
  logic                       rev_req, wrap, kill, grow_ok;
  logic [max_len_bit_len-1:0] new_len;
  logic [SNAKE_W-1:0]         shifted, stepped;

  // Candidate step, computed every cycle; the FSM decides whether it commits.
  always_comb begin
    head_x  = snake_q[HALF-1:0];
    head_y  = snake_q[num_len-1:HALF];
    rev_req = (bus.dir == (cur_dir_q ^ 2'b01));
    eff_dir = (bus.dir_valid && !rev_req) ? bus.dir : pend_dir_q;
    nx      = head_x;
    ny      = head_y;
    wrap    = 1'b0;
    case (eff_dir)
      D_UP: begin
        ny   = head_y - HALF'(1);
        wrap = (head_y == '0);
      end
      D_DOWN: begin
        ny   = head_y + HALF'(1);
        wrap = &head_y;
      end
      D_LEFT: begin
        nx   = head_x - HALF'(1);
        wrap = (head_x == '0);
      end
      default: begin
        nx   = head_x + HALF'(1);
        wrap = &head_x;
      end
    endcase
    kill    = WALL_KILL && wrap;
    shifted = {snake_q[SNAKE_W-num_len-1:0], ny, nx};
    grow_ok = (grow_q || bus.grow) && (len_q < GROW_LIMIT);
    new_len = grow_ok ? len_q + max_len_bit_len'(1) : len_q;
    stepped = shifted;
    // The old tail slides to index len on a non-growing step and is cleared here.
    for (int i = 0; i < max_len; i++) begin
      if (i >= int'(new_len)) begin
        stepped[i*num_len +: num_len] = '0;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    snake_d    = snake_q;
    len_d      = len_q;
    cur_dir_d  = cur_dir_q;
    pend_dir_d = pend_dir_q;
    grow_d     = grow_q;
    moved_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) state_d = RUN;
      end
      RUN: begin
        if (bus.stop) begin
          state_d = DEAD;
        end else begin
          if (bus.dir_valid && !rev_req) pend_dir_d = bus.dir;
          if (bus.grow) grow_d = 1'b1;
          if (bus.tick) begin
            if (kill) begin
              state_d = DEAD;
            end else begin
              snake_d    = stepped;
              len_d      = new_len;
              cur_dir_d  = eff_dir;
              pend_dir_d = eff_dir;
              grow_d     = 1'b0;
              moved_d    = 1'b1;
            end
          end
        end
      end
      DEAD: begin
        if (bus.start) begin
          state_d    = RUN;
          snake_d    = reset_layout();
          len_d      = LEN_INIT;
          cur_dir_d  = D_RIGHT;
          pend_dir_d = D_RIGHT;
          grow_d     = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      snake_q    <= reset_layout();
      len_q      <= LEN_INIT;
      cur_dir_q  <= D_RIGHT;
      pend_dir_q <= D_RIGHT;
      grow_q     <= 1'b0;
      moved_q    <= 1'b0;
    end else begin
      snake_q    <= snake_d;
      len_q      <= len_d;
      cur_dir_q  <= cur_dir_d;
      pend_dir_q <= pend_dir_d;
      grow_q     <= grow_d;
      moved_q    <= moved_d;
    end
  end

  assign bus.snake     = snake_q;
  assign bus.len       = len_q;
  assign bus.alive     = (state_q == RUN);
  assign bus.moved     = moved_q;
  assign bus.state_dbg = state_q;

endmodule

// File: tb/tb_snake_mover.sv
// Randomized bench for snake_mover against a coordinate-list reference model.
// The model keeps the body as a list of (x, y) cells, head first.
module tb_snake_mover;
  localparam int MAX_LEN  = 16;
  localparam int NUM_LEN  = 10;
  localparam int LEN_W    = 4;
  localparam int START_X  = 8;
  localparam int START_Y  = 8;
  localparam int INIT_LEN = 3;
  localparam int W        = MAX_LEN * NUM_LEN;
  localparam int SPAN     = 32;

`ifdef SNAKE_WALL_KILL_EN
  localparam bit KILL_EN = 1'b1;
`else
  localparam bit KILL_EN = 1'b0;
`endif

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  snake_mover_if #(.MAX_LEN(MAX_LEN), .NUM_LEN(NUM_LEN), .LEN_W(LEN_W)) bus ();

  snake_mover #(
    .max_len(MAX_LEN), .num_len(NUM_LEN), .max_len_bit_len(LEN_W),
    .START_X(START_X), .START_Y(START_Y), .INIT_LEN(INIT_LEN)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // reference model
  int mx[$];
  int my[$];
  int m_mode;   // 0 idle, 1 run, 2 dead
  int m_cur;
  int m_pend;
  bit m_grow;
  bit m_moved;

  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit is_reverse(input int a, input int b);
    return ((a < 2) == (b < 2)) && (a != b);
  endfunction

  function automatic logic [W-1:0] pack_body();
    logic [W-1:0] v;
    v = '0;
    for (int i = 0; i < mx.size(); i++) begin
      v[i*NUM_LEN +: NUM_LEN] = NUM_LEN'(my[i] * SPAN + mx[i]);
    end
    return v;
  endfunction

  task automatic model_layout();
    mx.delete();
    my.delete();
    for (int i = 0; i < INIT_LEN; i++) begin
      mx.push_back(START_X - i);
      my.push_back(START_Y);
    end
    m_cur  = 3;
    m_pend = 3;
    m_grow = 1'b0;
  endtask

  task automatic model_edge(input bit st, input bit tk, input int d, input bit dv,
                            input bit gr, input bit sp);
    int nx, ny, old_len;
    bit off;
    m_moved = 1'b0;
    case (m_mode)
      0: if (st) m_mode = 1;
      1: begin
        if (sp) begin
          m_mode = 2;
        end else begin
          if (dv && !is_reverse(d, m_cur)) m_pend = d;
          if (gr) m_grow = 1'b1;
          if (tk) begin
            nx = mx[0];
            ny = my[0];
            case (m_pend)
              0: ny = ny - 1;
              1: ny = ny + 1;
              2: nx = nx - 1;
              default: nx = nx + 1;
            endcase
            off = (nx < 0) || (nx >= SPAN) || (ny < 0) || (ny >= SPAN);
            if (KILL_EN && off) begin
              m_mode = 2;
            end else begin
              old_len = mx.size();
              m_cur = m_pend;
              mx.push_front((nx + SPAN) % SPAN);
              my.push_front((ny + SPAN) % SPAN);
              if (!(m_grow && old_len < MAX_LEN - 1)) begin
                void'(mx.pop_back());
                void'(my.pop_back());
              end
              m_grow  = 1'b0;
              m_moved = 1'b1;
            end
          end
        end
      end
      default: if (st) begin
        model_layout();
        m_mode = 1;
      end
    endcase
  endtask

  // scoreboard compare
  task automatic compare();
    logic [W-1:0] e;
    if (exp_q.size() == 0) begin
      check("exp_q_empty", W'(1), W'(0));
    end else begin
      e = exp_q.pop_front();
      check("snake", bus.snake, e);
    end
    check("len", W'(bus.len), W'(mx.size()));
    check("alive", W'(bus.alive), W'(m_mode == 1));
    check("moved", W'(bus.moved), W'(m_moved));
  endtask

  // driver: one clock cycle with the given inputs, then check at negedge
  task automatic cycle(input bit st, input bit tk, input int d, input bit dv,
                       input bit gr, input bit sp);
    bus.start     = st;
    bus.tick      = tk;
    bus.dir       = 2'(d);
    bus.dir_valid = dv;
    bus.grow      = gr;
    bus.stop      = sp;
    model_edge(st, tk, d, dv, gr, sp);
    exp_q.push_back(pack_body());
    @(posedge clk);
    @(negedge clk);
    compare();
  endtask

  task automatic tick_once();
    cycle(1'b0, 1'b1, 0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic async_reset_mid_step();
    bus.tick = 1'b1;
    #2;
    rst = 1'b1;
    model_layout();
    m_mode  = 0;
    m_moved = 1'b0;
    exp_q.push_back(pack_body());
    #1;
    compare();
    @(negedge clk);
    rst = 1'b0;
    exp_q.push_back(pack_body());
    compare();
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int guard;
    rst           = 1'b1;
    bus.start     = 1'b0;
    bus.tick      = 1'b0;
    bus.dir       = 2'd0;
    bus.dir_valid = 1'b0;
    bus.grow      = 1'b0;
    bus.stop      = 1'b0;
    model_layout();
    m_mode  = 0;
    m_moved = 1'b0;
    @(negedge clk);
    @(negedge clk);
    exp_q.push_back(pack_body());
    compare();
    check("rst_seg0", W'(bus.snake[9:0]), W'(264));
    check("rst_seg1", W'(bus.snake[19:10]), W'(263));
    check("rst_seg2", W'(bus.snake[29:20]), W'(262));
    rst = 1'b0;

    // idle ignores tick, then start and first step
    tick_once();
    cycle(1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    tick_once();
    check("step_seg0", W'(bus.snake[9:0]), W'(265));
    check("step_seg1", W'(bus.snake[19:10]), W'(264));
    check("step_seg2", W'(bus.snake[29:20]), W'(263));

    // reverse request dropped, then turn up in the same cycle as the tick
    cycle(1'b0, 1'b0, 2, 1'b1, 1'b0, 1'b0);
    tick_once();
    check("rev_head_x", W'(bus.snake[4:0]), W'(10));
    cycle(1'b0, 1'b1, 0, 1'b1, 1'b0, 1'b0);
    check("up_head_y", W'(bus.snake[9:5]), W'(7));

    // run right up to the edge and across it
    cycle(1'b0, 1'b1, 3, 1'b1, 1'b0, 1'b0);
    guard = 0;
    while (mx[0] != SPAN - 1 && guard < 40) begin
      tick_once();
      guard++;
    end
    tick_once();
    if (m_mode == 2) cycle(1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0);

    // grow handling and saturation
    cycle(1'b0, 1'b0, 0, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 0, 1'b0, 1'b1, 1'b0);
    tick_once();
    tick_once();
    guard = 0;
    while (mx.size() < MAX_LEN - 1 && guard < 20) begin
      cycle(1'b0, 1'b1, 1, 1'b1, 1'b1, 1'b0);
      guard++;
    end
    cycle(1'b0, 1'b1, 1, 1'b1, 1'b1, 1'b0);
    check("len_saturated", W'(bus.len), W'(MAX_LEN - 1));

    // stop wins over tick, dead freezes, start restarts
    cycle(1'b0, 1'b1, 0, 1'b0, 1'b0, 1'b1);
    tick_once();
    cycle(1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    tick_once();

    // asynchronous reset in the middle of a step
    async_reset_mid_step();
    tick_once();
    tick_once();
    cycle(1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0);

    // randomized traffic
    for (int n = 0; n < 1500; n++) begin
      cycle($urandom_range(0, 19) == 0, $urandom_range(0, 2) != 0,
            int'($urandom_range(0, 3)), $urandom_range(0, 1) == 1,
            $urandom_range(0, 3) == 0, $urandom_range(0, 59) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
